// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: state encoding and default sizes.
package bus_arbiter_pkg;

   // Default number of bus source requesters and the width of the data bus they share.
   localparam int REG_COUNT    = 16;
   localparam int REG_WIDTH    = 12;
   localparam int DEF_MAX_HOLD = 4;

   // Arbiter FSM states: idle, someone owns the bus, mandatory turnaround cycle.
   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GRANT = 2'd1,
      ARB_GAP   = 2'd2
   } arb_state_e;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Rotating-priority picker: finds the first set request at or after ptr_i,
// wrapping from N-1 back to 0. Purely combinational.
module bus_arbiter_rr_pick
   import bus_arbiter_pkg::*;
#(
   parameter int N     = REG_COUNT,
   parameter int IDX_W = 4
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [IDX_W-1:0] winner_o,
   output logic             found_o
);

   localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

   logic [IDX_W:0]   pos;
   logic [IDX_W-1:0] cand;

   // Walk every offset from the pointer upward with wrap; the first requester seen wins.
   always_comb begin
      // NOTE: every variable written here gets a default first so no path can infer a latch.
      winner_o = '0;
      found_o  = 1'b0;
      pos      = '0;
      cand     = '0;
      for (int i = 0; i < N; i++) begin
         pos = {1'b0, ptr_i} + (IDX_W+1)'(i);
         if (pos >= N_W) begin
            pos = pos - N_W;
         end
         cand = pos[IDX_W-1:0];
         if (!found_o && req_i[cand]) begin
            winner_o = cand;
            found_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin data bus arbiter: one-hot source select, bounded tenure
// (unless locked) and a single idle turnaround cycle between owners.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int Reg_count = REG_COUNT,
   parameter int IDX_W     = 4,
   parameter int MAX_HOLD  = DEF_MAX_HOLD,
   parameter int HOLD_W    = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [Reg_count-1:0] req,
   input  logic                 bus_lock,
   output logic [Reg_count-1:0] read_en,
   output logic                 grant_valid,
   output logic [IDX_W-1:0]     grant_idx,
   output logic                 grant_start
);

   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(Reg_count - 1);

   arb_state_e           state_q,       state_d;
   logic [IDX_W-1:0]     rr_ptr_q,      rr_ptr_d;
   logic [HOLD_W-1:0]    hold_cnt_q,    hold_cnt_d;
   logic [Reg_count-1:0] read_en_q,     read_en_d;
   logic                 grant_valid_q, grant_valid_d;
   logic [IDX_W-1:0]     grant_idx_q,   grant_idx_d;
   logic                 grant_start_q, grant_start_d;

   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_found;
   logic                 tenure_end;

   bus_arbiter_rr_pick #(
      .N     (Reg_count),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req_i    (req),
      .ptr_i    (rr_ptr_q),
      .winner_o (pick_idx),
      .found_o  (pick_found)
   );

   // Owner releases its request, or has used its full tenure without the lock.
   assign tenure_end = !req[grant_idx_q] || ((hold_cnt_q == HOLD_MAX) && !bus_lock);

   // Next-state and registered-output decisions for the arbitration FSM.
   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      hold_cnt_d    = hold_cnt_q;
      read_en_d     = read_en_q;
      grant_valid_d = grant_valid_q;
      grant_idx_d   = grant_idx_q;
      grant_start_d = 1'b0;
      unique case (state_q)
         ARB_IDLE, ARB_GAP: begin
            if (pick_found) begin
               state_d             = ARB_GRANT;
               read_en_d           = '0;
               read_en_d[pick_idx] = 1'b1;
               grant_valid_d       = 1'b1;
               grant_idx_d         = pick_idx;
               grant_start_d       = 1'b1;
               hold_cnt_d          = HOLD_W'(1);
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_GRANT: begin
            if (tenure_end) begin
               state_d       = ARB_GAP;
               read_en_d     = '0;
               grant_valid_d = 1'b0;
               rr_ptr_d      = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;
            end else if (hold_cnt_q != HOLD_MAX) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d       = ARB_IDLE;
            read_en_d     = '0;
            grant_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops the bus immediately with no turnaround.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ARB_IDLE;
         rr_ptr_q      <= '0;
         hold_cnt_q    <= '0;
         read_en_q     <= '0;
         grant_valid_q <= 1'b0;
         grant_idx_q   <= '0;
         grant_start_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         hold_cnt_q    <= hold_cnt_d;
         read_en_q     <= read_en_d;
         grant_valid_q <= grant_valid_d;
         grant_idx_q   <= grant_idx_d;
         grant_start_q <= grant_start_d;
      end
   end

   assign read_en     = read_en_q;
   assign grant_valid = grant_valid_q;
   assign grant_idx   = grant_idx_q;
   assign grant_start = grant_start_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural owner model.
module tb_bus_arbiter;

   localparam int N    = 16;
   localparam int MAXH = 4;

   logic         clk      = 1'b0;
   logic         reset    = 1'b1;
   logic [N-1:0] req      = '0;
   logic         bus_lock = 1'b0;
   logic [N-1:0] read_en;
   logic         grant_valid;
   logic [3:0]   grant_idx;
   logic         grant_start;

   int n_checks = 0;
   int n_err    = 0;
   bit cmp_en   = 1'b0;

   bus_arbiter #(
      .Reg_count (N),
      .IDX_W     (4),
      .MAX_HOLD  (MAXH),
      .HOLD_W    (3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .bus_lock    (bus_lock),
      .read_en     (read_en),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx),
      .grant_start (grant_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Behavioural model: who owns the bus, how long they have held it, and
   // where the next search starts. -1 means nobody (idle or turnaround).
   int m_owner = -1;
   int m_len   = 0;
   int m_ptr   = 0;
   int m_last  = 0;
   bit m_start = 1'b0;

   always @(posedge clk or negedge reset) begin : model
      int own, len, ptr, last, c;
      bit st;
      if (!reset) begin
         m_owner <= -1;
         m_len   <= 0;
         m_ptr   <= 0;
         m_last  <= 0;
         m_start <= 1'b0;
      end else begin
         own  = m_owner;
         len  = m_len;
         ptr  = m_ptr;
         last = m_last;
         st   = 1'b0;
         if (own >= 0) begin
            if (!req[own] || (len >= MAXH && !bus_lock)) begin
               ptr = (own + 1) % N;
               own = -1;
            end else begin
               len = len + 1;
            end
         end else begin
            for (int k = 0; k < N; k++) begin
               c = (ptr + k) % N;
               if (own < 0 && req[c]) begin
                  own  = c;
                  len  = 1;
                  last = c;
                  st   = 1'b1;
               end
            end
         end
         m_owner <= own;
         m_len   <= len;
         m_ptr   <= ptr;
         m_last  <= last;
         m_start <= st;
      end
   end

   // Compare every DUT output against the model on the falling edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("model_read_en", 32'(read_en), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
         check("model_grant_valid", 32'(grant_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
         check("model_grant_idx", 32'(grant_idx), 32'(m_last));
         check("model_grant_start", 32'(grant_start), 32'(m_start));
      end
   end

   task automatic apply_reset();
      @(negedge clk);
      #1;
      reset    = 1'b0;
      req      = '0;
      bus_lock = 1'b0;
      @(negedge clk);
      #1;
      reset = 1'b1;
   endtask

   logic [N-1:0] exp2 [6]  = '{16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0000, 16'h0010};
   logic [N-1:0] exp3 [20] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0000,
                               16'h0020, 16'h0020, 16'h0020, 16'h0020, 16'h0000,
                               16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000,
                               16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0000};
   int           exp_own3 [4] = '{0, 5, 15, 0};
   int           owners [$];
   logic [N-1:0] mask;
   logic [N-1:0] g;

   initial begin
      #1;
      reset  = 1'b0;
      cmp_en = 1'b1;

      // Reset held with every requester active: bus stays released.
      req = '1;
      @(negedge clk);
      @(negedge clk);
      check("t1_reset_read_en", 32'(read_en), 32'h0);
      check("t1_reset_valid", 32'(grant_valid), 32'h0);
      #1 reset = 1'b1;
      @(negedge clk);
      check("t1_first_read_en", 32'(read_en), 32'h0001);
      check("t1_first_idx", 32'(grant_idx), 32'h0);
      check("t1_first_start", 32'(grant_start), 32'h1);
      @(negedge clk);
      check("t1_start_pulse", 32'(grant_start), 32'h0);

      // Single requester is cut after the hold limit and re-granted after one gap.
      apply_reset();
      req = 16'h0010;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("t2_read_en", 32'(read_en), 32'(exp2[k]));
      end
      check("t2_regrant_start", 32'(grant_start), 32'h1);

      // Round robin with wrap across three held requesters.
      apply_reset();
      req = 16'h8021;
      owners.delete();
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("t3_read_en", 32'(read_en), 32'(exp3[k]));
         if (grant_start) owners.push_back(int'(grant_idx));
      end
      check("t3_num_tenures", 32'(owners.size()), 32'd4);
      for (int k = 0; k < 4 && k < owners.size(); k++) begin
         check("t3_owner_order", 32'(owners[k]), 32'(exp_own3[k]));
      end

      // Early release hands the bus to the next requester after one gap.
      apply_reset();
      req = 16'h0050;
      @(negedge clk);
      check("t4_c0", 32'(read_en), 32'h0010);
      @(negedge clk);
      check("t4_c1", 32'(read_en), 32'h0010);
      #1 req = 16'h0040;
      @(negedge clk);
      check("t4_gap", 32'(read_en), 32'h0000);
      @(negedge clk);
      check("t4_next", 32'(read_en), 32'h0040);

      // Lock extends the tenure past the limit; dropping it ends the tenure at that edge.
      apply_reset();
      req      = 16'h0041;
      bus_lock = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("t5_locked_hold", 32'(read_en), 32'h0001);
      end
      #1 bus_lock = 1'b0;
      @(negedge clk);
      check("t5_unlock_gap", 32'(read_en), 32'h0000);
      @(negedge clk);
      check("t5_next_read_en", 32'(read_en), 32'h0040);
      check("t5_next_idx", 32'(grant_idx), 32'd6);

      // Reset mid-tenure drops the bus immediately and restarts the pointer.
      apply_reset();
      req = 16'h0040;
      @(negedge clk);
      check("t6_owner", 32'(read_en), 32'h0040);
      #1 reset = 1'b0;
      #1;
      check("t6_async_read_en", 32'(read_en), 32'h0);
      check("t6_async_valid", 32'(grant_valid), 32'h0);
      check("t6_async_idx", 32'(grant_idx), 32'h0);
      req = 16'h0041;
      @(negedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("t6_after_read_en", 32'(read_en), 32'h0001);
      check("t6_after_idx", 32'(grant_idx), 32'h0);

      // Randomized traffic: held requests, lock toggles, glitches, occasional reset.
      apply_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         #1;
         reset    = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         mask     = N'($urandom & $urandom & $urandom);
         req      = req ^ mask;
         if ($urandom_range(0, 9) == 0) bus_lock = ~bus_lock;
         if ($urandom_range(0, 7) == 0) begin
            g = N'(1) << $urandom_range(0, N - 1);
            if ((req & g) == '0) begin
               #1 req = req | g;
               #1 req = req & ~g;
            end
         end
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
